// File: rtl/target_feeder.sv
// Double-buffered target feeder for the scoring systolic array: two channels load
// base-by-base and each streams one base on its own alternate toggle slot.
module target_feeder #(
  parameter int MAX_LEN = 256,
  parameter int LOG_LEN = $clog2(MAX_LEN) + 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       flush,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic       wr_chan,
  input  logic [1:0] wr_base,
  input  logic       wr_last,
  input  logic       toggle_in,
  output logic [1:0] data_out,
  output logic       en0,
  output logic       en1,
  output logic [1:0] busy,
  output logic [1:0] done,
  output logic [1:0] overflow
);

  localparam int IDX_W = $clog2(MAX_LEN);

  typedef enum logic [1:0] {EMPTY, LOADING, READY, STREAM} state_t;

  state_t             state_q [2];
  state_t             state_d [2];
  logic [LOG_LEN-1:0] wr_ptr  [2];
  logic [LOG_LEN-1:0] rd_ptr  [2];
  logic [LOG_LEN-1:0] len     [2];
  logic [1:0]         mem     [2][MAX_LEN];

  logic svc;
  logic wr_fire;
  logic wr_end;
  logic wr_trunc;
  logic rd_fire;
  logic rd_last;

  // Write handshake: a beat transfers on a clock edge where wr_valid & wr_ready;
  // wr_ready depends only on the target channel's state and flush, never on wr_valid.
  assign wr_ready = !flush && (state_q[wr_chan] == EMPTY || state_q[wr_chan] == LOADING);
  assign wr_fire  = wr_valid && wr_ready;
  assign wr_trunc = (wr_ptr[wr_chan] == LOG_LEN'(MAX_LEN - 1)) && !wr_last;
  assign wr_end   = wr_last || wr_trunc;

  // The channel serviced at this edge is the one whose slot begins after it.
  assign svc     = ~toggle_in;
  assign rd_fire = !flush && (state_q[svc] == READY || state_q[svc] == STREAM);
  assign rd_last = (rd_ptr[svc] == len[svc] - LOG_LEN'(1));

  always_comb begin
    for (int ch = 0; ch < 2; ch++) begin
      state_d[ch] = state_q[ch];
      if (flush) begin
        state_d[ch] = EMPTY;
      end else begin
        if (wr_fire && wr_chan == 1'(ch))
          state_d[ch] = wr_end ? READY : LOADING;
        if (rd_fire && svc == 1'(ch))
          state_d[ch] = rd_last ? EMPTY : STREAM;
      end
    end
  end

  always_comb begin
    for (int ch = 0; ch < 2; ch++)
      busy[ch] = (state_q[ch] != EMPTY);
  end

  always_ff @(posedge clk) begin
    if (wr_fire)
      mem[wr_chan][wr_ptr[wr_chan][IDX_W-1:0]] <= wr_base;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int ch = 0; ch < 2; ch++) begin
        state_q[ch] <= EMPTY;
        wr_ptr[ch]  <= '0;
        rd_ptr[ch]  <= '0;
        len[ch]     <= '0;
      end
      data_out <= '0;
      en0      <= 1'b0;
      en1      <= 1'b0;
      done     <= '0;
      overflow <= '0;
    end else begin
      state_q[0] <= state_d[0];
      state_q[1] <= state_d[1];
      data_out   <= '0;
      en0        <= 1'b0;
      en1        <= 1'b0;
      done       <= '0;
      if (flush) begin
        for (int ch = 0; ch < 2; ch++) begin
          wr_ptr[ch] <= '0;
          rd_ptr[ch] <= '0;
          len[ch]    <= '0;
        end
        overflow <= '0;
      end else begin
        // Write and read can never target the same channel in one cycle.
        if (wr_fire) begin
          wr_ptr[wr_chan] <= wr_ptr[wr_chan] + LOG_LEN'(1);
          if (wr_end)
            len[wr_chan] <= wr_ptr[wr_chan] + LOG_LEN'(1);
          if (wr_trunc)
            overflow[wr_chan] <= 1'b1;
        end
        if (rd_fire) begin
          data_out <= mem[svc][rd_ptr[svc][IDX_W-1:0]];
          en0      <= !svc;
          en1      <= svc;
          if (rd_last) begin
            done[svc]   <= 1'b1;
            rd_ptr[svc] <= '0;
            wr_ptr[svc] <= '0;
          end else begin
            rd_ptr[svc] <= rd_ptr[svc] + LOG_LEN'(1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_target_feeder.sv
// Directed bench for target_feeder: a per-cycle vector table for one channel plus
// hand-written sequences checked through per-channel expected-base queues.
module tb_target_feeder;

  logic       clk = 1'b0;
  logic       rst;
  logic       flush;
  logic       wr_valid;
  logic       wr_ready;
  logic       wr_chan;
  logic [1:0] wr_base;
  logic       wr_last;
  logic       toggle_in;
  logic [1:0] data_out;
  logic       en0;
  logic       en1;
  logic [1:0] busy;
  logic [1:0] done;
  logic [1:0] overflow;

  target_feeder #(.MAX_LEN(256)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_chan(wr_chan),
    .wr_base(wr_base), .wr_last(wr_last), .toggle_in(toggle_in),
    .data_out(data_out), .en0(en0), .en1(en1),
    .busy(busy), .done(done), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [1:0] exp_q0[$];
  logic [1:0] exp_q1[$];
  int en0_cnt, en1_cnt, done0_cnt, done1_cnt;

  typedef struct {
    logic       wv;
    logic [1:0] base;
    logic       last;
    logic       exp_rdy;
    logic       exp_en0;
    logic [1:0] exp_data;
    logic       exp_done0;
    logic [1:0] exp_busy;
  } vec_t;

  vec_t vecs [13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic monitor();
    logic exp_dn0;
    logic exp_dn1;
    exp_dn0 = 1'b0;
    exp_dn1 = 1'b0;
    check("en_exclusive", {31'b0, en0 & en1}, 32'd0);
    if (en0) begin
      en0_cnt++;
      check("en0_slot", {31'b0, toggle_in}, 32'd0);
      if (exp_q0.size() == 0) begin
        checks++; errors++;
        $display("FAIL ch0_unexpected_base: got %0h, expected no base", data_out);
      end else begin
        check("ch0_data", {30'b0, data_out}, {30'b0, exp_q0.pop_front()});
        exp_dn0 = (exp_q0.size() == 0);
      end
    end
    if (en1) begin
      en1_cnt++;
      check("en1_slot", {31'b0, toggle_in}, 32'd1);
      if (exp_q1.size() == 0) begin
        checks++; errors++;
        $display("FAIL ch1_unexpected_base: got %0h, expected no base", data_out);
      end else begin
        check("ch1_data", {30'b0, data_out}, {30'b0, exp_q1.pop_front()});
        exp_dn1 = (exp_q1.size() == 0);
      end
    end
    if (!en0 && !en1)
      check("data_idle", {30'b0, data_out}, 32'd0);
    check("done0", {31'b0, done[0]}, {31'b0, exp_dn0});
    check("done1", {31'b0, done[1]}, {31'b0, exp_dn1});
    if (done[0]) done0_cnt++;
    if (done[1]) done1_cnt++;
  endtask

  // One clock: the array's toggle flips just after every rising edge.
  task automatic cycle();
    @(posedge clk);
    #1;
    toggle_in = ~toggle_in;
    monitor();
  endtask

  task automatic clear_counts();
    en0_cnt = 0; en1_cnt = 0; done0_cnt = 0; done1_cnt = 0;
  endtask

  task automatic write_beat(input logic ch, input logic [1:0] base, input logic last);
    int n;
    n = 0;
    wr_valid = 1'b1; wr_chan = ch; wr_base = base; wr_last = last;
    #1;
    while (!wr_ready && n < 600) begin
      cycle();
      #1;
      n++;
    end
    if (!wr_ready) begin
      checks++; errors++;
      $display("FAIL write_timeout: got wr_ready=0 for %0d cycles, expected 1", n);
    end else begin
      if (ch) exp_q1.push_back(base);
      else    exp_q0.push_back(base);
    end
    cycle();
    wr_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while ((busy != 2'b00 || exp_q0.size() != 0 || exp_q1.size() != 0) && n < budget) begin
      cycle();
      n++;
    end
    check("idle_reached", {31'b0, n >= budget}, 32'd0);
  endtask

  task automatic wait_en(input logic ch, input int target, input int budget);
    int n;
    n = 0;
    while ((ch ? en1_cnt : en0_cnt) < target && n < budget) begin
      cycle();
      n++;
    end
    check("en_reached", {31'b0, n >= budget}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by 200000 ns, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0]  = '{1'b1, 2'b10, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 2'b01};
    vecs[1]  = '{1'b1, 2'b11, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 2'b01};
    vecs[2]  = '{1'b1, 2'b00, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 2'b01};
    vecs[3]  = '{1'b1, 2'b01, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 2'b01};
    vecs[4]  = '{1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b01};
    vecs[5]  = '{1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 2'b10, 1'b0, 2'b01};
    vecs[6]  = '{1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b01};
    vecs[7]  = '{1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 2'b11, 1'b0, 2'b01};
    vecs[8]  = '{1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b01};
    vecs[9]  = '{1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 2'b01};
    vecs[10] = '{1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b01};
    vecs[11] = '{1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 2'b01, 1'b1, 2'b00};
    vecs[12] = '{1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 2'b00};

    // Clock/reset block.
    rst = 1'b0; flush = 1'b0; wr_valid = 1'b0; wr_chan = 1'b0;
    wr_base = 2'b00; wr_last = 1'b0; toggle_in = 1'b0;
    clear_counts();
    repeat (3) cycle();
    check("rst_en0", {31'b0, en0}, 32'd0);
    check("rst_en1", {31'b0, en1}, 32'd0);
    check("rst_data", {30'b0, data_out}, 32'd0);
    check("rst_busy", {30'b0, busy}, 32'd0);
    check("rst_done", {30'b0, done}, 32'd0);
    check("rst_overflow", {30'b0, overflow}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cycle();
      check("idle_wr_ready", {31'b0, wr_ready}, 32'd1);
      check("idle_en", {30'b0, en1, en0}, 32'd0);
      check("idle_busy", {30'b0, busy}, 32'd0);
    end

    // Vector table: ch0 = 10,11,00,01 starting in a toggle_in=0 cycle.
    if (toggle_in != 1'b0) cycle();
    clear_counts();
    for (int i = 0; i < 13; i++) begin
      wr_valid = vecs[i].wv; wr_chan = 1'b0; wr_base = vecs[i].base; wr_last = vecs[i].last;
      #1;
      check($sformatf("vec%0d_wr_ready", i), {31'b0, wr_ready}, {31'b0, vecs[i].exp_rdy});
      if (vecs[i].wv) exp_q0.push_back(vecs[i].base);
      cycle();
      check($sformatf("vec%0d_en0", i), {31'b0, en0}, {31'b0, vecs[i].exp_en0});
      check($sformatf("vec%0d_en1", i), {31'b0, en1}, 32'd0);
      check($sformatf("vec%0d_data", i), {30'b0, data_out}, {30'b0, vecs[i].exp_data});
      check($sformatf("vec%0d_done0", i), {31'b0, done[0]}, {31'b0, vecs[i].exp_done0});
      check($sformatf("vec%0d_busy", i), {30'b0, busy}, {30'b0, vecs[i].exp_busy});
    end
    wr_valid = 1'b0;
    check("vec_done_count", done0_cnt, 1);

    // ch0 streams 8 bases while ch1 loads 5.
    clear_counts();
    for (int i = 0; i < 8; i++) write_beat(1'b0, 2'((i * 3) % 4), i == 7);
    for (int i = 0; i < 5; i++) write_beat(1'b1, 2'((i + 1) % 4), i == 4);
    wait_idle(200);
    check("il_en0_count", en0_cnt, 8);
    check("il_en1_count", en1_cnt, 5);
    check("il_done0_count", done0_cnt, 1);
    check("il_done1_count", done1_cnt, 1);
    check("il_overflow", {30'b0, overflow}, 32'd0);

    // 256 beats with no last: the final one truncates the sequence.
    clear_counts();
    for (int i = 0; i < 256; i++) write_beat(1'b0, 2'($urandom_range(0, 3)), 1'b0);
    check("ovf_flag", {30'b0, overflow}, 32'd1);
    check("ovf_busy0", {31'b0, busy[0]}, 32'd1);
    wr_valid = 1'b1; wr_chan = 1'b0; wr_base = 2'b11; wr_last = 1'b0;
    #1;
    check("ovf_beat257_refused", {31'b0, wr_ready}, 32'd0);
    cycle();
    wr_valid = 1'b0;
    wait_idle(1200);
    check("ovf_en0_count", en0_cnt, 256);
    check("ovf_done0_count", done0_cnt, 1);
    check("ovf_sticky", {30'b0, overflow}, 32'd1);

    // Writes aimed at ch1 while it streams are refused.
    clear_counts();
    for (int i = 0; i < 6; i++) write_beat(1'b1, 2'(3 - (i % 4)), i == 5);
    wait_en(1'b1, 1, 20);
    for (int i = 0; i < 3; i++) begin
      wr_valid = 1'b1; wr_chan = 1'b1; wr_base = 2'b11; wr_last = 1'b1;
      #1;
      check("stream_wr_refused", {31'b0, wr_ready}, 32'd0);
      cycle();
    end
    wr_valid = 1'b0;
    wait_idle(100);
    check("ws_en1_count", en1_cnt, 6);
    check("ws_done1_count", done1_cnt, 1);

    // Flush after base 3 of 6 on ch0, with a simultaneous ch1 write.
    clear_counts();
    for (int i = 0; i < 6; i++) write_beat(1'b0, 2'((i + 1) % 4), i == 5);
    wait_en(1'b0, 3, 40);
    flush = 1'b1; wr_valid = 1'b1; wr_chan = 1'b1; wr_base = 2'b10; wr_last = 1'b1;
    #1;
    check("flush_wr_ready", {31'b0, wr_ready}, 32'd0);
    cycle();
    flush = 1'b0; wr_valid = 1'b0;
    exp_q0.delete();
    check("flush_en", {30'b0, en1, en0}, 32'd0);
    check("flush_busy", {30'b0, busy}, 32'd0);
    check("flush_overflow", {30'b0, overflow}, 32'd0);
    check("flush_done", {30'b0, done}, 32'd0);
    repeat (4) cycle();
    check("flush_ch1_not_stored", {30'b0, busy}, 32'd0);
    check("flush_en0_count", en0_cnt, 3);
    write_beat(1'b0, 2'b11, 1'b0);
    write_beat(1'b0, 2'b01, 1'b1);
    wait_idle(40);
    check("reload_en0_count", en0_cnt, 5);
    check("reload_done0_count", done0_cnt, 1);

    // Asynchronous reset mid-stream.
    clear_counts();
    for (int i = 0; i < 4; i++) write_beat(1'b0, 2'(i), i == 3);
    wait_en(1'b0, 1, 20);
    #2;
    rst = 1'b0;
    #1;
    check("arst_en", {30'b0, en1, en0}, 32'd0);
    check("arst_data", {30'b0, data_out}, 32'd0);
    check("arst_done", {30'b0, done}, 32'd0);
    check("arst_busy", {30'b0, busy}, 32'd0);
    check("arst_overflow", {30'b0, overflow}, 32'd0);
    exp_q0.delete();
    exp_q1.delete();
    @(negedge clk);
    rst = 1'b1;
    repeat (4) cycle();
    check("arst_after_busy", {30'b0, busy}, 32'd0);
    check("arst_after_en0_count", en0_cnt, 1);
    #1;
    check("arst_after_wr_ready", {31'b0, wr_ready}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/target_feeder.md
Name: target_feeder

Overview:
- Upstream stage of the scoring systolic array.
- Buffers two independent target sequences (channel 0 and channel 1), loaded base-by-base over a valid/ready write port.
- Streams each loaded sequence into the array on its own alternate clock slot, driving data_in/en0/en1 in lock-step with the array's toggle output.
- Double-buffering lets one channel load while the other streams.

Parameters:
- MAX_LEN, 256, maximum target length per channel in bases.
- LOG_LEN, log2b(MAX_LEN)+1, width of the per-channel length and pointer counters.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low.
- flush  in  1  synchronous abort; returns both channels to EMPTY.
- wr_valid  in  1  write beat valid.
- wr_ready  out  1  write beat accepted when wr_valid & wr_ready.
- wr_chan  in  1  target channel of the write beat.
- wr_base  in  2  2-bit base code, stored verbatim.
- wr_last  in  1  marks the final base of the sequence.
- toggle_in  in  1  toggle from the scoring array.
- data_out  out  2  base to the array's data_in.
- en0  out  1  channel-0 base valid this cycle.
- en1  out  1  channel-1 base valid this cycle.
- busy  out  2  per channel: state != EMPTY.
- done  out  2  one-cycle pulse per channel, coincident with its last base on data_out.
- overflow  out  2  sticky per channel: sequence truncated at MAX_LEN.

Behaviour:
- Reset (async, rst=0):
  - All channel states go to EMPTY; pointers and lengths go to 0.
  - data_out=0, en0=en1=0, done=0, overflow=0.
  - Buffer contents are don't-care.
- Per-channel FSM: EMPTY -> LOADING -> READY -> STREAM -> EMPTY.
- wr_ready is combinational: state[wr_chan] is EMPTY or LOADING, and flush=0.
- Accepted beat:
  - Writes mem[wr_chan][wr_ptr] and increments wr_ptr.
  - EMPTY moves to LOADING on the first beat.
  - A beat with wr_last=1 sets len=wr_ptr+1 and the state moves to READY (a 1-base sequence goes EMPTY->READY directly).
- Overflow: a beat at wr_ptr=MAX_LEN-1 with wr_last=0 is stored and treated as last. overflow[ch] is set and stays set until flush or reset.
- Slot rule: at each rising edge, sample t=toggle_in; the serviced channel is c=~t. Outputs are registered, so the base driven lands in the cycle where toggle_in equals c.
- At that edge, if state[c] is READY or STREAM:
  - data_out<=mem[c][rd_ptr], en_c<=1, en_other<=0, rd_ptr++.
  - READY becomes STREAM.
  - When rd_ptr==len-1: done[c]<=1, state goes to EMPTY and pointers clear.
- Otherwise at that edge: data_out<=0, en0=en1=0, done=0.
- Each channel therefore gets at most one base every 2 cycles. The first base is issued at the first own-slot edge after READY is reached (READY-to-en latency is 1 or 2 cycles).
- A channel re-entering EMPTY needs at least one accepted beat before it can stream again. This guarantees at least one en-low own slot between consecutive sequences, which the array uses as end-of-sequence.
- Loading one channel while the other streams is permitted.
- A write to a channel that is READY or STREAM is refused (wr_ready=0 for that wr_chan) with no side effect.
- flush=1 takes priority over a same-cycle write or stream. Next edge: both channels EMPTY, pointers cleared, overflow cleared, data_out=0, en=0, done=0.
- en0 and en1 are never high in the same cycle.
- done pulses exactly once per streamed sequence.

Test Plan:
- Reset then idle toggle: after rst release, wr_ready=1, en0=en1=0, data_out=0 for 20 cycles; assert rst low mid-stream -> all outputs 0 immediately (asynchronous).
- Load ch0 = A,G,T,C (10,11,00,01) with last on C -> ch0 READY; en0 high on 4 alternate cycles with data_out 10,11,00,01 exactly in cycles where toggle_in=0; done[0] pulses with 01; busy[0] falls.
- Load ch1 = 5 bases while ch0 streams 8 bases -> en0/en1 interleave, never overlapping; each sequence arrives in order; done[0] and done[1] each pulse once.
- Write 257 beats to ch0 with no last, MAX_LEN=256 -> beat 256 ends the sequence, overflow[0]=1, beat 257 refused (wr_ready=0 while READY/STREAM); stream emits exactly 256 bases.
- Write to ch1 during its STREAM -> wr_ready=0, no corruption of the streamed bases.
- Assert flush mid-stream of ch0 at base 3 of 6, with a simultaneous ch1 write -> next cycle en0=en1=0, busy=00, overflow=00; ch1 write not stored; reload of ch0 streams from base 0.
